apb_regfile_slave: RTL and testbench

- Parametrised APB slave register file, the next generation of the team's APB bus interface.
- Adds configurable data/address width, register count, programmable wait states, byte strobes, and read-only/error decoding.
- Sits between the APB interconnect and peripheral cores such as the I2S engine: it exposes registers as flat vectors and accepts hardware status for read-only slots.

---
 rtl/apb_regfile_slave.sv | 159 +++++++++++++++
 tb/tb_apb_regfile_slave.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_regfile_slave.sv
// APB register file slave: parametrised width/count, wait states, byte
// strobes, read-only hardware status slots and error decoding.
module apb_regfile_slave #(
    parameter int unsigned                 APB_ADDR_WIDTH = 32,
    parameter int unsigned                 APB_DATA_WIDTH = 32,
    parameter int unsigned                 NUM_REGS       = 8,
    parameter int unsigned                 WAIT_STATES    = 0,
    parameter logic [NUM_REGS-1:0]         RO_MASK        = '0,
    parameter logic [APB_DATA_WIDTH-1:0]   RESET_VAL      = '0
) (
    input  logic                               pclk,
    input  logic                               preset,
    input  logic [APB_ADDR_WIDTH-1:0]          paddr,
    input  logic                               psel,
    input  logic                               penable,
    input  logic                               pwrite,
    input  logic [APB_DATA_WIDTH-1:0]          pwdata,
    input  logic [APB_DATA_WIDTH/8-1:0]        pstrb,
    output logic [APB_DATA_WIDTH-1:0]          prdata,
    output logic                               pready,
    output logic                               pslverr,
    output logic [NUM_REGS*APB_DATA_WIDTH-1:0] reg_q,
    input  logic [NUM_REGS*APB_DATA_WIDTH-1:0] hw_status,
    output logic [NUM_REGS-1:0]                wr_pulse
);

    localparam int unsigned NB   = APB_DATA_WIDTH / 8;
    localparam int unsigned LSB  = $clog2(NB);
    localparam int unsigned IDXW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [APB_ADDR_WIDTH-1:0] ALIGN_MASK =
        APB_ADDR_WIDTH'((64'd1 << LSB) - 64'd1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                    state, state_n;
    logic [3:0]                cnt;
    logic                      cnt_en;
    logic                      start;
    logic                      commit;
    logic [IDXW-1:0]           idx_q;
    logic                      err_q;
    logic                      write_q;
    logic [APB_DATA_WIDTH-1:0] wdata_q;
    logic [NB-1:0]             strb_q;
    logic [APB_ADDR_WIDTH-1:0] idx_full;
    logic [IDXW-1:0]           idx_sel;
    logic                      ro_hit;
    logic                      dec_err;
    logic [APB_DATA_WIDTH-1:0] rd_word;
    logic [APB_DATA_WIDTH-1:0] regs [NUM_REGS];

    // RO slots expose hardware status, RW slots expose their storage
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regq
        assign reg_q[i*APB_DATA_WIDTH +: APB_DATA_WIDTH] =
            RO_MASK[i] ? hw_status[i*APB_DATA_WIDTH +: APB_DATA_WIDTH] : regs[i];
    end

    // Address decode at full shifted width so high bits never alias
    always_comb begin
        idx_full = paddr >> LSB;
        idx_sel  = idx_full[IDXW-1:0];
        ro_hit   = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (idx_sel == IDXW'(i) && RO_MASK[i]) ro_hit = 1'b1;
        end
        dec_err = (idx_full >= APB_ADDR_WIDTH'(NUM_REGS)) ||
                  ((paddr & ALIGN_MASK) != '0) ||
                  (pwrite && ro_hit);
    end

    // Read mux over the latched register index
    always_comb begin
        rd_word = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (idx_q == IDXW'(i)) rd_word = reg_q[i*APB_DATA_WIDTH +: APB_DATA_WIDTH];
        end
    end

    // FSM state register
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) state <= IDLE;
        else        state <= state_n;
    end

    // FSM next state and bus response; pready is combinational in ACCESS
    always_comb begin
        state_n = state;
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = '0;
        commit  = 1'b0;
        cnt_en  = 1'b0;
        start   = 1'b0;
        case (state)
            IDLE: begin
                if (psel && !penable) begin
                    start   = 1'b1;
                    state_n = SETUP;
                end
            end
            SETUP: begin
                state_n = psel ? ACCESS : IDLE;
            end
            ACCESS: begin
                if (!psel) begin
                    state_n = IDLE;
                end else if (penable) begin
                    if (cnt == 4'(WAIT_STATES)) begin
                        pready  = 1'b1;
                        pslverr = err_q;
                        if (!write_q && !err_q) prdata = rd_word;
                        commit  = write_q && !err_q;
                        state_n = IDLE;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Request capture, wait counter, register writes and write pulses
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            cnt      <= '0;
            idx_q    <= '0;
            err_q    <= 1'b0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
            wr_pulse <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
        end else begin
            wr_pulse <= '0;
            if (start) begin
                cnt     <= '0;
                idx_q   <= idx_sel;
                err_q   <= dec_err;
                write_q <= pwrite;
                wdata_q <= pwdata;
                strb_q  <= pstrb;
            end else if (cnt_en) begin
                cnt <= cnt + 4'd1;
            end
            if (commit) begin
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        wr_pulse[i] <= 1'b1;
                        for (int unsigned b = 0; b < NB; b++) begin
                            if (strb_q[b]) regs[i][b*8 +: 8] <= wdata_q[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench for apb_regfile_slave: three instances with 0, 3 and 2 wait
// states share one APB bus, each selected by its own psel.
module tb_apb_regfile_slave;

    logic         pclk = 1'b0;
    logic         preset = 1'b1;
    logic [31:0]  paddr = '0;
    logic [2:0]   psel_v = '0;
    logic         penable = 1'b0;
    logic         pwrite = 1'b0;
    logic [31:0]  pwdata = '0;
    logic [3:0]   pstrb = '0;
    logic [255:0] hw_status;

    logic [31:0]  prdata_f, prdata_s, prdata_m;
    logic         pready_f, pready_s, pready_m;
    logic         pslverr_f, pslverr_s, pslverr_m;
    logic [255:0] reg_q_f, reg_q_s, reg_q_m;
    logic [7:0]   wr_pulse_f, wr_pulse_s, wr_pulse_m;

    int unsigned  cur = 0;
    logic [31:0]  s_prdata;
    logic         s_pready, s_pslverr;
    logic [7:0]   s_wr_pulse;

    int unsigned  n_checks = 0;
    int unsigned  n_fail = 0;

    always #5 pclk = ~pclk;

    always_comb begin
        for (int i = 0; i < 8; i++) hw_status[i*32 +: 32] = 32'h5555_0000 + 32'(i);
        hw_status[31:0] = 32'hDEAD_BEEF;
    end

    apb_regfile_slave #(.WAIT_STATES(0), .RO_MASK(8'h01)) u_fast (
        .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel_v[0]), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_f), .pready(pready_f),
        .pslverr(pslverr_f), .reg_q(reg_q_f), .hw_status(hw_status), .wr_pulse(wr_pulse_f));

    apb_regfile_slave #(.WAIT_STATES(3)) u_slow (
        .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel_v[1]), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_s), .pready(pready_s),
        .pslverr(pslverr_s), .reg_q(reg_q_s), .hw_status(hw_status), .wr_pulse(wr_pulse_s));

    apb_regfile_slave #(.WAIT_STATES(2)) u_mid (
        .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel_v[2]), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_m), .pready(pready_m),
        .pslverr(pslverr_m), .reg_q(reg_q_m), .hw_status(hw_status), .wr_pulse(wr_pulse_m));

    always_comb begin
        case (cur)
            1: begin s_prdata = prdata_s; s_pready = pready_s; s_pslverr = pslverr_s; s_wr_pulse = wr_pulse_s; end
            2: begin s_prdata = prdata_m; s_pready = pready_m; s_pslverr = pslverr_m; s_wr_pulse = wr_pulse_m; end
            default: begin s_prdata = prdata_f; s_pready = pready_f; s_pslverr = pslverr_f; s_wr_pulse = wr_pulse_f; end
        endcase
    end

    // One APB transfer; returns at the falling edge of the pready cycle with psel held,
    // so a following transfer starts its setup phase immediately.
    task automatic xfer(input int unsigned d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb,
                        output logic [31:0] rdata, output logic err,
                        output int unsigned cycles, output logic early_nz);
        logic done;
        cur = d;
        @(posedge pclk); #1;
        psel_v = '0; psel_v[d] = 1'b1; penable = 1'b0;
        pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
        @(posedge pclk); #1;
        penable = 1'b1;
        cycles = 0; early_nz = 1'b0; rdata = '0; err = 1'b0; done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge pclk);
            cycles++;
            if (s_pready) begin
                rdata = s_prdata; err = s_pslverr; done = 1'b1;
            end else if (s_prdata !== 32'h0) begin
                early_nz = 1'b1;
            end
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL xfer_timeout addr=%h: pready never seen in 40 cycles", addr);
        end
    endtask

    task automatic bus_idle();
        @(posedge pclk); #1;
        psel_v = '0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge pclk);
        #1 preset = 1'b0;
        @(negedge pclk);
        n_checks++; if (pready_f !== 1'b0) begin n_fail++; $display("FAIL reset_pready got=%b exp=0", pready_f); end
        n_checks++; if (pslverr_f !== 1'b0) begin n_fail++; $display("FAIL reset_pslverr got=%b exp=0", pslverr_f); end
        n_checks++; if (prdata_f !== 32'h0) begin n_fail++; $display("FAIL reset_prdata got=%h exp=0", prdata_f); end
        n_checks++; if (wr_pulse_f !== 8'h0) begin n_fail++; $display("FAIL reset_wr_pulse got=%h exp=0", wr_pulse_f); end
        n_checks++; if (reg_q_f[63:32] !== 32'h0) begin n_fail++; $display("FAIL reset_reg1 got=%h exp=0", reg_q_f[63:32]); end
        n_checks++; if (reg_q_f[31:0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL reset_ro_slot got=%h exp=deadbeef", reg_q_f[31:0]); end
    endtask

    task automatic test_read_defaults();
        logic [31:0] rd, exp; logic err, en; int unsigned cyc;
        for (int i = 0; i < 8; i++) begin
            xfer(0, 1'b0, 32'(i*4), 32'h0, 4'h0, rd, err, cyc, en);
            exp = (i == 0) ? 32'hDEAD_BEEF : 32'h0;
            n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL default_read[%0d] got=%h exp=%h", i, rd, exp); end
            n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL default_err[%0d] got=%b exp=0", i, err); end
            n_checks++; if (cyc != 2) begin n_fail++; $display("FAIL default_latency[%0d] got=%0d exp=2", i, cyc); end
        end
        bus_idle();
    endtask

    task automatic test_full_write();
        logic [31:0] rd; logic err, en; int unsigned cyc;
        xfer(0, 1'b1, 32'h08, 32'hA5A5_1234, 4'hF, rd, err, cyc, en);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL full_write_err got=%b exp=0", err); end
        bus_idle();
        @(negedge pclk);
        n_checks++; if (wr_pulse_f !== 8'h04) begin n_fail++; $display("FAIL wr_pulse_high got=%h exp=04", wr_pulse_f); end
        @(negedge pclk);
        n_checks++; if (wr_pulse_f !== 8'h00) begin n_fail++; $display("FAIL wr_pulse_one_cycle got=%h exp=00", wr_pulse_f); end
        n_checks++; if (reg_q_f[95:64] !== 32'hA5A5_1234) begin n_fail++; $display("FAIL full_write_reg_q got=%h exp=a5a51234", reg_q_f[95:64]); end
        xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, rd, err, cyc, en);
        n_checks++; if (rd !== 32'hA5A5_1234) begin n_fail++; $display("FAIL full_write_readback got=%h exp=a5a51234", rd); end
        bus_idle();
    endtask

    task automatic test_partial_write();
        logic [31:0] rd; logic err, en; int unsigned cyc;
        xfer(0, 1'b1, 32'h0C, 32'h0000_0000, 4'hF, rd, err, cyc, en);
        xfer(0, 1'b1, 32'h0C, 32'hFFFF_FFFF, 4'b0010, rd, err, cyc, en);
        xfer(0, 1'b0, 32'h0C, 32'h0, 4'h0, rd, err, cyc, en);
        n_checks++; if (rd !== 32'h0000_FF00) begin n_fail++; $display("FAIL partial_write got=%h exp=0000ff00", rd); end
        xfer(0, 1'b1, 32'h0C, 32'h1234_5678, 4'b0000, rd, err, cyc, en);
        bus_idle();
        @(negedge pclk);
        n_checks++; if (wr_pulse_f !== 8'h08) begin n_fail++; $display("FAIL zero_strb_pulse got=%h exp=08", wr_pulse_f); end
        n_checks++; if (reg_q_f[127:96] !== 32'h0000_FF00) begin n_fail++; $display("FAIL zero_strb_data got=%h exp=0000ff00", reg_q_f[127:96]); end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; logic err, en; int unsigned cyc;
        xfer(1, 1'b1, 32'h04, 32'h1111_2222, 4'hF, rd, err, cyc, en);
        n_checks++; if (cyc != 5) begin n_fail++; $display("FAIL ws3_write_latency got=%0d exp=5", cyc); end
        xfer(1, 1'b0, 32'h04, 32'h0, 4'h0, rd, err, cyc, en);
        n_checks++; if (cyc != 5) begin n_fail++; $display("FAIL ws3_read_latency got=%0d exp=5", cyc); end
        n_checks++; if (en !== 1'b0) begin n_fail++; $display("FAIL ws3_prdata_early got=%b exp=0", en); end
        n_checks++; if (rd !== 32'h1111_2222) begin n_fail++; $display("FAIL ws3_readback got=%h exp=11112222", rd); end
        bus_idle();
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic err, en; int unsigned cyc;
        xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, err, cyc, en);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_range got=%b exp=1", err); end
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL err_range_data got=%h exp=0", rd); end
        xfer(0, 1'b0, 32'h03, 32'h0, 4'h0, rd, err, cyc, en);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_unaligned got=%b exp=1", err); end
        xfer(0, 1'b0, 32'h8000_0008, 32'h0, 4'h0, rd, err, cyc, en);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_alias got=%b exp=1", err); end
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL err_alias_data got=%h exp=0", rd); end
        xfer(0, 1'b1, 32'h00, 32'h1234_5678, 4'hF, rd, err, cyc, en);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_ro_write got=%b exp=1", err); end
        bus_idle();
        @(negedge pclk);
        n_checks++; if (wr_pulse_f !== 8'h00) begin n_fail++; $display("FAIL ro_write_pulse got=%h exp=00", wr_pulse_f); end
        xfer(0, 1'b0, 32'h00, 32'h0, 4'h0, rd, err, cyc, en);
        n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ro_read got=%h exp=deadbeef", rd); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL ro_read_err got=%b exp=0", err); end
        xfer(0, 1'b1, 32'h24, 32'hFFFF_FFFF, 4'hF, rd, err, cyc, en);
        bus_idle();
        @(negedge pclk);
        n_checks++; if (wr_pulse_f !== 8'h00) begin n_fail++; $display("FAIL range_write_pulse got=%h exp=00", wr_pulse_f); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic err, en; int unsigned cyc;
        xfer(0, 1'b1, 32'h10, 32'h0BAD_F00D, 4'hF, rd, err, cyc, en);
        n_checks++; if (cyc != 2) begin n_fail++; $display("FAIL b2b_write_latency got=%0d exp=2", cyc); end
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, err, cyc, en);
        n_checks++; if (cyc != 2) begin n_fail++; $display("FAIL b2b_read_latency got=%0d exp=2", cyc); end
        n_checks++; if (rd !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL b2b_readback got=%h exp=0badf00d", rd); end
        xfer(0, 1'b0, 32'h14, 32'h0, 4'h0, rd, err, cyc, en);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL b2b_rw_ignores_hw got=%h exp=0", rd); end
        bus_idle();
    endtask

    task automatic test_abandon();
        logic [31:0] rd; logic err, en; int unsigned cyc; logic seen;
        xfer(2, 1'b1, 32'h08, 32'h0000_00AA, 4'hF, rd, err, cyc, en);
        n_checks++; if (cyc != 4) begin n_fail++; $display("FAIL ws2_latency got=%0d exp=4", cyc); end
        bus_idle();
        cur = 2;
        @(posedge pclk); #1;
        psel_v = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h1234_5678; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        @(negedge pclk);
        seen = pready_m;
        @(posedge pclk); #1;
        psel_v = '0; penable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge pclk);
            seen = seen | pready_m | (|wr_pulse_m);
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abandon_activity got=%b exp=0", seen); end
        xfer(2, 1'b0, 32'h08, 32'h0, 4'h0, rd, err, cyc, en);
        n_checks++; if (rd !== 32'h0000_00AA) begin n_fail++; $display("FAIL abandon_data got=%h exp=000000aa", rd); end
        bus_idle();
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic err, en; int unsigned cyc; logic done;
        cur = 1;
        @(posedge pclk); #1;
        psel_v = 3'b010; penable = 1'b0; pwrite = 1'b0; paddr = 32'h04;
        @(posedge pclk); #1;
        penable = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge pclk);
            if (pready_s) done = 1'b1;
        end
        n_checks++; if (done !== 1'b1 || prdata_s !== 32'h1111_2222) begin n_fail++; $display("FAIL rstmid_pre got=%b/%h exp=1/11112222", done, prdata_s); end
        #1 preset = 1'b1;
        #1;
        n_checks++; if (pready_s !== 1'b0) begin n_fail++; $display("FAIL rstmid_pready got=%b exp=0", pready_s); end
        n_checks++; if (prdata_s !== 32'h0) begin n_fail++; $display("FAIL rstmid_prdata got=%h exp=0", prdata_s); end
        n_checks++; if (reg_q_s[63:32] !== 32'h0) begin n_fail++; $display("FAIL rstmid_reg got=%h exp=0", reg_q_s[63:32]); end
        psel_v = '0; penable = 1'b0;
        repeat (2) @(posedge pclk);
        #1 preset = 1'b0;
        xfer(1, 1'b0, 32'h04, 32'h0, 4'h0, rd, err, cyc, en);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rstmid_readback got=%h exp=0", rd); end
        n_checks++; if (cyc != 5) begin n_fail++; $display("FAIL rstmid_latency got=%0d exp=5", cyc); end
        bus_idle();
    endtask

    initial begin
        test_reset();
        test_read_defaults();
        test_full_write();
        test_partial_write();
        test_wait_states();
        test_errors();
        test_back_to_back();
        test_abandon();
        test_reset_mid();
        repeat (2) @(posedge pclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
